multi_timer: RTL
================

# multi_timer

Parametrised multi-channel countdown timer for the coffee-maker controller. It replaces single-channel, fixed-width timing with N independent channels. Each channel supports one-shot or periodic mode, pause/resume, abort, retrigger and a readable remaining count. All channels share one internal prescaler that derives a seconds tick from clk_100MHz, so no separate divided clock domain is needed. The brewing FSM drives it directly: typical uses are pump time, heater time and keep-warm period.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- TICK_HZ, 1: countdown tick rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- N_CH, 4: number of independent channels, 1..16.
- CNT_W, 8: width of each channel's count, in ticks.
- clk_100MHz  in  1  system clock; the single clock of the block.
- reset  in  1  synchronous, active-high reset.
- start  in  N_CH  per-channel start/retrigger, sampled each cycle.
- stop  in  N_CH  per-channel abort.
- pause  in  N_CH  level; while high, the channel holds its count.
- periodic  in  N_CH  mode, sampled at start: 1 = auto-reload, 0 = one-shot.
- value  in  N_CH*CNT_W  channel i uses bits [i*CNT_W +: CNT_W]; duration in ticks.
- t_expired  out  N_CH  one-cycle pulse per expiry.
- busy  out  N_CH  high in RUN or PAUSED.
- remaining  out  N_CH*CNT_W  current count per channel.
- tick  out  1  one-cycle prescaler pulse, for debug and other blocks.

## Operation
- Prescaler: free-running counter 0..DIV-1. tick = 1 for the cycle in which the counter wraps from DIV-1 to 0. It is not restarted by start.
- Per-channel FSM states:
  - IDLE: busy=0. remaining holds 0 after expiry or stop, or after reset.
  - RUN: busy=1; counts down.
  - PAUSED: busy=1; count is frozen.
- Per-channel priority, highest first: reset, stop, start, pause/tick.
- stop: go to IDLE, remaining ← 0, no t_expired.
- start with value ≠ 0: latch value into remaining and into a reload register, latch periodic, go to RUN. This applies from any state (retrigger).
- start with value = 0: stay in or go to IDLE, remaining ← 0, t_expired pulses. This holds even if periodic=1.
- RUN, tick, remaining > 1: remaining decrements by 1.
- RUN, tick, remaining = 1, one-shot: remaining ← 0, t_expired pulses, go to IDLE.
- RUN, tick, remaining = 1, periodic: remaining ← reload value, t_expired pulses, stay in RUN.
- RUN with pause=1: go to PAUSED. A tick in that same cycle is ignored.
- PAUSED with pause=0: go to RUN. Ticks are counted from the next cycle onward.
- start while pause=1: go to PAUSED with the value loaded.
- Arithmetic: unsigned CNT_W. The count never wraps below 0.
- Channels are fully independent, except that they share tick.

## Timing
- Reset values: t_expired=0, busy=0, remaining=0, tick=0, prescaler=0, all channels IDLE.
- All outputs are registered. Nothing passes combinationally from input to output.
- start sampled at edge k: busy and remaining=value are visible after edge k.
- A start coinciding with a tick: the tick is not applied to that channel.
- Expiry: t_expired is high for exactly one cycle, in the same cycle that remaining shows 0 (one-shot) or the reload value (periodic).
- Latency from start to expiry: between (value-1)·DIV+1 and value·DIV cycles, because the prescaler phase is free-running.
- A reset asserted mid-count takes effect at the next edge. No pending expiry pulse is emitted.

## Structure
- Shared package or include: the state encodings (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2) and the DIV computation plus its elaboration-time legality checks (integer DIV, DIV ≥ 2, N_CH range).
- Sub-module tick_gen holds the prescaler and tick output, parameterised by DIV.
- The channel FSMs are a generate loop in multi_timer.

## Test plan
- Use CLK_HZ=10, TICK_HZ=1 (DIV=10), N_CH=4, CNT_W=8 for all scenarios.
- Reset: hold reset for 3 cycles, then check all outputs 0. Release reset, then tick pulses every 10 cycles, with the first tick 10 cycles after release.
- One-shot: ch0 start with value=3, periodic=0. Expect busy=1 next cycle, remaining 3→2→1→0 on successive ticks, t_expired[0] one pulse on the 3rd tick, then busy=0. Other channels stay idle.
- Periodic and stop: ch1 value=2, periodic=1. Expect a t_expired[1] pulse every 2 ticks for 3 periods, with remaining reloaded to 2. Assert stop mid-period: busy=0, remaining=0, no further pulses.
- Pause: ch2 value=4. Hold pause for 3 ticks after the first tick. Expect remaining frozen at 3 and busy=1. After release, expiry occurs 3 ticks later.
- Boundary cases:
  - start with value=0 gives t_expired for one cycle and busy stays 0.
  - start coinciding with a tick loads the full value, not value-1.
  - Retrigger at remaining=1 reloads the count and emits no expiry.
  - Simultaneous start and stop on ch3 results in IDLE.
  - Reset asserted while ch0 has remaining=1 on the tick cycle produces no t_expired.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Shared definitions for multi_timer: channel state encoding, prescaler
// divide computation and parameter legality checks.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2
  } ch_state_e;

  // Clock cycles per countdown tick; 0 flags an unusable TICK_HZ.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
  endfunction

  // DIV must be an exact integer >= 2 and the channel count must be 1..16.
  function automatic bit params_ok(input int unsigned clk_hz,
                                   input int unsigned tick_hz,
                                   input int unsigned n_ch);
    if (tick_hz == 0) return 1'b0;
    if ((clk_hz % tick_hz) != 0) return 1'b0;
    if (calc_div(clk_hz, tick_hz) < 2) return 1'b0;
    if (n_ch < 1 || n_ch > 16) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/multi_timer_tick_gen.sv
// Free-running prescaler shared by all timer channels. Emits a registered
// one-cycle tick in the cycle after the counter wraps from DIV-1 to 0.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk_100MHz,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            tick_q;

  // Prescaler count and tick pulse; never restarted by channel activity.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CntW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CntW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel countdown timer. Each channel is an independent one-shot or
// periodic down-counter with pause, abort and retrigger, clocked by a
// shared prescaler tick.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       pause,
  input  logic [N_CH-1:0]       periodic,
  input  logic [N_CH*CNT_W-1:0] value,
  output logic [N_CH-1:0]       t_expired,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH*CNT_W-1:0] remaining,
  output logic                  tick
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

  if (!params_ok(CLK_HZ, TICK_HZ, N_CH)) begin : g_bad_params
    $error("multi_timer: CLK_HZ/TICK_HZ must be an integer >= 2 and N_CH in 1..16");
  end

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .tick       (tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_e        state_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] reload_q;
    logic             per_q;
    logic             exp_q;
    logic [CNT_W-1:0] val;

    assign val = value[i*CNT_W +: CNT_W];

    // Channel FSM; priority is stop, then start, then pause/tick.
    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        state_q  <= StIdle;
        rem_q    <= '0;
        reload_q <= '0;
        per_q    <= 1'b0;
        exp_q    <= 1'b0;
      end else begin
        exp_q <= 1'b0;
        if (stop[i]) begin
          state_q <= StIdle;
          rem_q   <= '0;
        end else if (start[i]) begin
          if (val == '0) begin
            // Zero duration expires immediately, even in periodic mode.
            state_q <= StIdle;
            rem_q   <= '0;
            exp_q   <= 1'b1;
          end else begin
            state_q  <= pause[i] ? StPaused : StRun;
            rem_q    <= val;
            reload_q <= val;
            per_q    <= periodic[i];
          end
        end else begin
          unique case (state_q)
            StRun: begin
              if (pause[i]) begin
                state_q <= StPaused;
              end else if (tick) begin
                if (rem_q > CNT_W'(1)) begin
                  rem_q <= rem_q - CNT_W'(1);
                end else begin
                  exp_q <= 1'b1;
                  if (per_q) begin
                    rem_q <= reload_q;
                  end else begin
                    rem_q   <= '0;
                    state_q <= StIdle;
                  end
                end
              end
            end
            StPaused: begin
              if (!pause[i]) state_q <= StRun;
            end
            default: ;
          endcase
        end
      end
    end

    assign busy[i]                     = (state_q != StIdle);
    assign t_expired[i]                = exp_q;
    assign remaining[i*CNT_W +: CNT_W] = rem_q;
  end

endmodule
